// File: rtl/unidade_controle.sv
// unidade_controle: control unit of the 16-bit multicycle processor.
// A free-running 2-bit step counter (T0..T3) plus combinational decode of
// ir[8:0] = instruction[15:7] into bus select, register write enables,
// accumulator / ALU-result enables and ALU operation select.
//
// Optional feature: define UNIDADE_DONE_EN to add the `done` output, which
// is high during the last active step of each instruction (T1 for mv/mvi,
// T3 for ALU ops, never for reserved opcodes or while in reset).
//
// Contract with the instruction source: there is no handshake. The source
// must hold ir stable for the whole four-step window that begins at T0;
// outputs follow ir combinationally, so a change mid-window is reflected
// immediately. resetn is active-high despite its name.
module unidade_controle (
  input  logic       clock,
  input  logic       resetn,
  input  logic [8:0] ir,
  output logic [1:0] counter,
  output logic [3:0] mux_key,
  output logic [7:0] regs_enable,
  output logic       a_enable,
  output logic       alu_output_enable,
  output logic [1:0] alu_op_selec
`ifdef UNIDADE_DONE_EN
  ,
  output logic       done
`endif
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  localparam logic [3:0] KEY_G    = 4'd8;
  localparam logic [3:0] KEY_DIN  = 4'd9;
  localparam logic [3:0] KEY_IDLE = 4'd15;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t step_q;
  step_t step_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_alu;
  logic       is_move;
  logic [7:0] rx_onehot;

  assign opcode    = ir[8:6];
  assign rx        = ir[5:3];
  assign ry        = ir[2:0];
  assign is_alu    = opcode[2];
  assign is_move   = (opcode == OP_MV) || (opcode == OP_MVI);
  assign rx_onehot = 8'd1 << rx;

  // Next step: always advances, wrapping T3 -> T0; no stalls.
  always_comb begin
    step_d = step_t'(step_q + 2'd1);
  end

  // Step counter register; reset parks it at T0.
  always_ff @(posedge clock) begin
    if (resetn) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  assign counter = step_q;

  // Decode of the current step and instruction into datapath controls.
  always_comb begin
    mux_key           = KEY_IDLE;
    regs_enable       = 8'd0;
    a_enable          = 1'b0;
    alu_output_enable = 1'b0;
    alu_op_selec      = 2'b00;
    if (!resetn) begin
      case (step_q)
        T1: begin
          if (is_move) begin
            mux_key     = (opcode == OP_MVI) ? KEY_DIN : {1'b0, ry};
            regs_enable = rx_onehot;
          end else if (is_alu) begin
            mux_key  = {1'b0, rx};
            a_enable = 1'b1;
          end
        end
        T2: begin
          if (is_alu) begin
            mux_key           = {1'b0, ry};
            alu_output_enable = 1'b1;
            alu_op_selec      = opcode[1:0];
          end
        end
        T3: begin
          if (is_alu) begin
            mux_key     = KEY_G;
            regs_enable = rx_onehot;
          end
        end
        default: begin
          // T0: fetch/setup slot, everything idle.
        end
      endcase
    end
  end

`ifdef UNIDADE_DONE_EN
  // Last active step of the instruction.
  always_comb begin
    done = 1'b0;
    if (!resetn) begin
      done = (is_move && (step_q == T1)) || (is_alu && (step_q == T3));
    end
  end
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Testbench for unidade_controle: directed instruction sequences plus
// randomized instructions and resets, checked by a scoreboard against a
// behavioural model of the instruction timing.
module tb_unidade_controle;

  // ---------------- clock / reset ----------------
  logic       clock;
  logic       resetn;
  logic [8:0] ir;
  logic [1:0] counter;
  logic [3:0] mux_key;
  logic [7:0] regs_enable;
  logic       a_enable;
  logic       alu_output_enable;
  logic [1:0] alu_op_selec;
`ifdef UNIDADE_DONE_EN
  logic       done;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  unidade_controle dut (
    .clock            (clock),
    .resetn           (resetn),
    .ir               (ir),
    .counter          (counter),
    .mux_key          (mux_key),
    .regs_enable      (regs_enable),
    .a_enable         (a_enable),
    .alu_output_enable(alu_output_enable),
    .alu_op_selec     (alu_op_selec)
`ifdef UNIDADE_DONE_EN
    ,
    .done             (done)
`endif
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 18;  // {counter, mux_key, regs_enable, a, g, alu_op}
  logic [W-1:0] exp_q[$];
  logic         exp_done_q[$];
  int           errors = 0;
  int           checks = 0;
  int           model_step = 0;  // step the DUT is in during this cycle

  // ---------------- reference model ----------------
  // What each instruction class does in each of its four steps.
  function automatic logic [W-1:0] model(input int step, input logic rst,
                                         input logic [8:0] i);
    logic [2:0] op;
    int         dst;
    int         src;
    int         key;
    int         wr_reg;
    logic       ld_a;
    logic       ld_g;
    logic [1:0] fn;
    logic [7:0] wr_vec;
    op = i[8:6];
    dst = int'(i[5:3]);
    src = int'(i[2:0]);
    key = 15;
    wr_reg = -1;
    ld_a = 1'b0;
    ld_g = 1'b0;
    fn = 2'b00;
    if (!rst) begin
      if (op == 3'b000 && step == 1) begin
        key = src; wr_reg = dst;
      end else if (op == 3'b001 && step == 1) begin
        key = 9; wr_reg = dst;
      end else if (op >= 3'b100) begin
        if (step == 1) begin key = dst; ld_a = 1'b1; end
        if (step == 2) begin key = src; ld_g = 1'b1; fn = op[1:0]; end
        if (step == 3) begin key = 8; wr_reg = dst; end
      end
    end
    wr_vec = 8'd0;
    if (wr_reg >= 0) wr_vec[wr_reg] = 1'b1;
    return {2'(step), 4'(key), wr_vec, ld_a, ld_g, fn};
  endfunction

  function automatic logic model_done(input int step, input logic rst,
                                      input logic [8:0] i);
    if (rst) return 1'b0;
    if (i[8:6] <= 3'b001) return step == 1;
    if (i[8:6] >= 3'b100) return step == 3;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Advance one clock: update the model step from the reset value the DUT
  // sampled on this edge, then apply new inputs and queue the expectation.
  task automatic drive(input logic r, input logic [8:0] i);
    @(posedge clock);
    model_step = resetn ? 0 : (model_step + 1) % 4;
    #1;
    resetn = r;
    ir = i;
    exp_q.push_back(model(model_step, r, i));
    exp_done_q.push_back(model_done(model_step, r, i));
  endtask

  task automatic run_instr(input logic [8:0] i);
    for (int s = 0; s < 4; s++) drive(1'b0, i);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      logic         ed;
      e = exp_q.pop_front();
      ed = exp_done_q.pop_front();
      a = {counter, mux_key, regs_enable, a_enable, alu_output_enable, alu_op_selec};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t ir=%b rst=%b: got cnt=%0d key=%0d regs=%b a=%b g=%b op=%b, want cnt=%0d key=%0d regs=%b a=%b g=%b op=%b",
                 $time, ir, resetn, a[17:16], a[15:12], a[11:4], a[3], a[2], a[1:0],
                 e[17:16], e[15:12], e[11:4], e[3], e[2], e[1:0]);
      end
      checks++;
      if ($countones(regs_enable) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t regs_enable=%b, want at most one bit", $time, regs_enable);
      end
`ifdef UNIDADE_DONE_EN
      checks++;
      if (done !== ed) begin
        errors++;
        $display("FAIL done t=%0t got %b want %b", $time, done, ed);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] rand_ir;
    int         wait_cycles;
    resetn = 1'b1;
    ir = 9'd0;

    // Reset, then counter should run 0,1,2,3,0 with reserved no-op.
    drive(1'b1, 9'b101_000_000);
    run_instr(9'b010_011_100);

    // Directed sequences from the plan.
    run_instr(9'b101_000_000);   // sub R0,R0
    run_instr(9'b101_001_000);   // sub R1,R0
    run_instr(9'b001_000_001);   // mvi R0
    run_instr(9'b100_000_000);   // add R0,R0
    run_instr(9'b000_111_010);   // mv R7,R2
    run_instr(9'b110_011_101);   // and R3,R5
    run_instr(9'b111_110_110);   // or R6,R6
    run_instr(9'b011_111_111);   // reserved

    // Reset at T2 of an add: idle that cycle, no T3 write, restart at T0.
    drive(1'b0, 9'b100_010_001);
    drive(1'b0, 9'b100_010_001);
    drive(1'b1, 9'b100_010_001);
    run_instr(9'b100_010_001);

    // Randomized: new instruction at each T0, occasional reset or mid-window ir change.
    rand_ir = 9'($urandom);
    for (int c = 0; c < 600; c++) begin
      logic r;
      logic [8:0] nir;
      r = ($urandom_range(0, 19) == 0);
      // The step this cycle will show is decided by the edge about to come.
      nir = ir;
      if ((resetn ? 0 : (model_step + 1) % 4) == 0) rand_ir = 9'($urandom);
      nir = rand_ir;
      if ($urandom_range(0, 29) == 0) nir = 9'($urandom);
      drive(r, nir);
    end

    // Let the monitor drain, bounded.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
